// File: rtl/mua_rate_accumulator.sv
// Per-channel spike-rate accumulator: read-modify-write of each channel's RAM word
// {count, prev_rate, enc}, emitting the finished rate at every bin boundary.
module mua_rate_accumulator #(
  parameter int CH_NUM          = 16,
  parameter int CH_BIT          = 4,
  parameter int SPIKE_RATE_BIT  = 4,
  parameter int ENCODER_NUM_BIT = 3,
  parameter int ENC_DEFAULT     = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [CH_BIT-1:0]                           in_ch,
  input  logic                                        in_spike,
  input  logic                                        in_bin_end,
  output logic [CH_BIT-1:0]                           ram_raddr,
  input  logic [2*SPIKE_RATE_BIT+ENCODER_NUM_BIT-1:0] ram_dout,
  output logic                                        ram_we,
  output logic [CH_BIT-1:0]                           ram_waddr,
  output logic [2*SPIKE_RATE_BIT+ENCODER_NUM_BIT-1:0] ram_din,
  output logic                                        out_valid,
  output logic [CH_BIT-1:0]                           out_ch,
  output logic [SPIKE_RATE_BIT-1:0]                   out_rate,
  output logic [SPIKE_RATE_BIT-1:0]                   out_prev_rate,
  output logic [ENCODER_NUM_BIT-1:0]                  out_enc,
  output logic                                        busy
);

  localparam int W = 2*SPIKE_RATE_BIT + ENCODER_NUM_BIT;
  localparam logic [SPIKE_RATE_BIT-1:0]  RATE_MAX = '1;
  localparam logic [CH_BIT-1:0]          LAST_CH  = CH_BIT'(CH_NUM - 1);
  localparam logic [ENCODER_NUM_BIT-1:0] ENC_INIT = ENCODER_NUM_BIT'(ENC_DEFAULT);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                     state_q, state_d;
  logic [CH_BIT-1:0]          cnt_q;
  logic                       accept;

  logic                       vld_p1;
  logic [CH_BIT-1:0]          ch_p1;
  logic                       spike_p1;
  logic                       bin_end_p1;

  logic                       vld_p2;
  logic [CH_BIT-1:0]          ch_p2;
  logic [W-1:0]               word_p2;

  logic [W-1:0]               cur_word;
  logic [W-1:0]               new_word;
  logic [SPIKE_RATE_BIT-1:0]  cur_count;
  logic [SPIKE_RATE_BIT-1:0]  cur_prev;
  logic [SPIKE_RATE_BIT-1:0]  sum;
  logic [ENCODER_NUM_BIT-1:0] cur_enc;

  function automatic logic [SPIKE_RATE_BIT-1:0] sat_inc(
    input logic [SPIKE_RATE_BIT-1:0] a,
    input logic                      inc
  );
    if (inc && (a != RATE_MAX)) return a + SPIKE_RATE_BIT'(1);
    return a;
  endfunction

  assign in_ready  = (state_q == S_RUN);
  assign busy      = (state_q == S_INIT);
  assign ram_raddr = in_ch;
  assign accept    = in_valid && in_ready;

  // Stage 1: RAM read data is valid; merge with the word still in flight to the RAM
  always_comb begin
    cur_word = ram_dout;
    if (vld_p2 && (ch_p2 == ch_p1)) cur_word = word_p2;
    {cur_count, cur_prev, cur_enc} = cur_word;
    sum = sat_inc(cur_count, spike_p1);
    if (bin_end_p1) new_word = {SPIKE_RATE_BIT'(0), sum, cur_enc};
    else            new_word = {sum, cur_prev, cur_enc};
  end

  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    ram_waddr = ch_p1;
    ram_din   = new_word;
    if (state_q == S_INIT && cnt_q == LAST_CH) state_d = S_RUN;
    // A write pending while rst is high is dropped, not landed.
    if (!rst) begin
      if (state_q == S_INIT) begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_din   = {SPIKE_RATE_BIT'(0), SPIKE_RATE_BIT'(0), ENC_INIT};
      end else begin
        ram_we = vld_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_INIT;
      cnt_q         <= '0;
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      out_valid     <= 1'b0;
      out_ch        <= '0;
      out_rate      <= '0;
      out_prev_rate <= '0;
      out_enc       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) cnt_q <= cnt_q + CH_BIT'(1);
      vld_p1    <= accept;
      vld_p2    <= vld_p1;
      out_valid <= vld_p1 && bin_end_p1;
      if (vld_p1 && bin_end_p1) begin
        out_ch        <= ch_p1;
        out_rate      <= sum;
        out_prev_rate <= cur_prev;
        out_enc       <= cur_enc;
      end
    end
  end

  // Stage 0 -> 1 sample capture, stage 1 -> 2 written-word capture
  always_ff @(posedge clk) begin
    ch_p1      <= in_ch;
    spike_p1   <= in_spike;
    bin_end_p1 <= in_bin_end;
    ch_p2      <= ch_p1;
    word_p2    <= new_word;
  end

endmodule

// File: tb/tb_mua_rate_accumulator.sv
// Self-checking bench for mua_rate_accumulator: RAM model, per-channel reference
// model, directed vector table, corner sequences and randomized traffic.
module tb_mua_rate_accumulator;

  localparam int CH_NUM = 16;
  localparam int CH_BIT = 4;
  localparam int SRB    = 4;
  localparam int ENB    = 3;
  localparam int W      = 2*SRB + ENB;
  localparam int ENC    = 5;
  localparam int RMAX   = (1 << SRB) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CH_BIT-1:0] in_ch = '0;
  logic              in_spike = 1'b0;
  logic              in_bin_end = 1'b0;
  logic [CH_BIT-1:0] ram_raddr;
  logic [W-1:0]      ram_dout;
  logic              ram_we;
  logic [CH_BIT-1:0] ram_waddr;
  logic [W-1:0]      ram_din;
  logic              out_valid;
  logic [CH_BIT-1:0] out_ch;
  logic [SRB-1:0]    out_rate;
  logic [SRB-1:0]    out_prev_rate;
  logic [ENB-1:0]    out_enc;
  logic              busy;

  logic [W-1:0]      mem [CH_NUM];

  int errors = 0;
  int checks = 0;

  // reference model state, one entry per channel
  int ref_cnt  [CH_NUM];
  int ref_prev [CH_NUM];
  int ref_enc  [CH_NUM];
  bit pend_v;
  int pend_ch, pend_rate, pend_prev, pend_enc;
  int obs_ov, obs_ch, obs_rate, obs_prev;

  typedef struct {
    bit v; int ch; bit sp; bit be;
    bit e_ov; int e_ch; int e_rate; int e_prev;
  } vec_t;
  vec_t tbl [12];

  mua_rate_accumulator #(
    .CH_NUM(CH_NUM), .CH_BIT(CH_BIT), .SPIKE_RATE_BIT(SRB),
    .ENCODER_NUM_BIT(ENB), .ENC_DEFAULT(ENC)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_spike(in_spike), .in_bin_end(in_bin_end),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_din(ram_din), .out_valid(out_valid),
    .out_ch(out_ch), .out_rate(out_rate), .out_prev_rate(out_prev_rate),
    .out_enc(out_enc), .busy(busy)
  );

  always #5 clk = ~clk;

  // read-first dual-port RAM with registered read data
  always @(posedge clk) begin
    ram_dout <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mword(input int c);
    return {SRB'(ref_cnt[c]), SRB'(ref_prev[c]), ENB'(ref_enc[c])};
  endfunction

  function automatic logic [W-1:0] init_word();
    return {SRB'(0), SRB'(0), ENB'(ENC)};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH_NUM; c++) begin
      ref_cnt[c] = 0; ref_prev[c] = 0; ref_enc[c] = ENC;
    end
    pend_v = 1'b0;
  endtask

  // One clock cycle: present a sample, check the output owed by the previous
  // sample and the RAM write of this one against the reference model.
  task automatic cyc(input bit v, input int ch, input bit sp, input bit be);
    int s;
    @(negedge clk);
    in_valid = v; in_ch = CH_BIT'(ch); in_spike = sp; in_bin_end = be;
    @(posedge clk);
    #1;
    obs_ov = int'(out_valid); obs_ch = int'(out_ch);
    obs_rate = int'(out_rate); obs_prev = int'(out_prev_rate);
    chk("out_valid", 32'(out_valid), 32'(pend_v));
    if (pend_v) begin
      chk("out_ch", 32'(out_ch), pend_ch);
      chk("out_rate", 32'(out_rate), pend_rate);
      chk("out_prev_rate", 32'(out_prev_rate), pend_prev);
      chk("out_enc", 32'(out_enc), pend_enc);
    end
    pend_v = 1'b0;
    chk("ram_we", 32'(ram_we), 32'(v));
    if (v) begin
      s = ref_cnt[ch] + int'(sp);
      if (s > RMAX) s = RMAX;
      if (be) begin
        pend_v = 1'b1; pend_ch = ch; pend_rate = s;
        pend_prev = ref_prev[ch]; pend_enc = ref_enc[ch];
        ref_prev[ch] = s; ref_cnt[ch] = 0;
      end else begin
        ref_cnt[ch] = s;
      end
      chk("ram_waddr", 32'(ram_waddr), ch);
      chk("ram_din", 32'(ram_din), 32'(mword(ch)));
    end
  endtask

  // Called at the negedge where rst has just been released.
  task automatic init_sweep(input bit poke);
    in_valid = poke; in_ch = '0; in_spike = 1'b1; in_bin_end = 1'b1;
    for (int i = 0; i < CH_NUM; i++) begin
      #1;
      chk("init_busy", 32'(busy), 1);
      chk("init_ready", 32'(in_ready), 0);
      chk("init_we", 32'(ram_we), 1);
      chk("init_waddr", 32'(ram_waddr), i);
      chk("init_din", 32'(ram_din), 32'(init_word()));
      chk("init_out_valid", 32'(out_valid), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("run_busy", 32'(busy), 0);
    chk("run_ready", 32'(in_ready), 1);
    chk("run_we_idle", 32'(ram_we), 0);
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1, 5, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 5, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 5, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 5, 1, 1, 1, 5, 3, 0};
    tbl[4]  = '{1, 7, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 7, 1, 1, 1, 7, 2, 0};
    tbl[6]  = '{1, 5, 1, 1, 1, 5, 1, 3};
    tbl[7]  = '{1, 2, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 9, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 2, 1, 1, 1, 2, 2, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 9, 0, 1, 1, 9, 1, 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_out_rate", 32'(out_rate), 0);
    @(negedge clk);
    rst = 1'b0;
    init_sweep(1'b0);

    // directed vectors
    for (int i = 0; i <= 12; i++) begin
      if (i < 12) cyc(tbl[i].v, tbl[i].ch, tbl[i].sp, tbl[i].be);
      else        cyc(1'b0, 0, 1'b0, 1'b0);
      if (i == 4) chk("tbl_mem5_bin1", 32'(mem[5]), 32'({SRB'(0), SRB'(3), ENB'(ENC)}));
      if (i > 0) begin
        chk("tbl_ov", obs_ov, 32'(tbl[i-1].e_ov));
        if (tbl[i-1].e_ov) begin
          chk("tbl_ch", obs_ch, tbl[i-1].e_ch);
          chk("tbl_rate", obs_rate, tbl[i-1].e_rate);
          chk("tbl_prev", obs_prev, tbl[i-1].e_prev);
        end
      end
    end
    chk("tbl_mem5", 32'(mem[5]), 32'({SRB'(0), SRB'(1), ENB'(ENC)}));
    chk("tbl_mem7", 32'(mem[7]), 32'({SRB'(0), SRB'(2), ENB'(ENC)}));
    chk("tbl_mem9", 32'(mem[9]), 32'({SRB'(0), SRB'(1), ENB'(ENC)}));

    // saturation: more spikes than the count field can hold
    for (int k = 0; k < RMAX + 3; k++) cyc(1'b1, 5, 1'b1, 1'b0);
    cyc(1'b1, 5, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("sat_ov", obs_ov, 1);
    chk("sat_rate", obs_rate, RMAX);
    chk("sat_prev", obs_prev, 1);

    // randomized traffic, biased onto a few channels to provoke forwarding
    for (int k = 0; k < 400; k++) begin
      int ch;
      ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, CH_NUM-1))
                                       : int'($urandom_range(4, 6));
      cyc($urandom_range(0, 3) != 0, ch, 1'($urandom_range(0, 1)),
          $urandom_range(0, 4) == 0);
    end
    cyc(1'b0, 0, 1'b0, 1'b0);
    for (int c = 0; c < CH_NUM; c++) chk("rand_mem", 32'(mem[c]), 32'(mword(c)));

    // reset while a bin_end sample sits in stage 1
    cyc(1'b1, 4, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_ch = CH_BIT'(4); in_spike = 1'b1; in_bin_end = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_we", 32'(ram_we), 1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("mid_rst_we", 32'(ram_we), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_mem4", 32'(mem[4]), 32'(mword(4)));
    chk("mid_rst_busy", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b0;
    init_sweep(1'b1);

    // round robin, two bins, only ch3 spiking
    for (int j = 0; j <= 2*CH_NUM; j++) begin
      if (j < 2*CH_NUM) cyc(1'b1, j % CH_NUM, (j % CH_NUM) == 3, 1'b1);
      else              cyc(1'b0, 0, 1'b0, 1'b0);
      if (j >= 1) begin
        int p, c;
        p = j - 1;
        c = p % CH_NUM;
        chk("rr_ov", obs_ov, 1);
        chk("rr_ch", obs_ch, c);
        if (p >= CH_NUM) begin
          chk("rr_rate", obs_rate, (c == 3) ? 1 : 0);
          chk("rr_prev", obs_prev, (c == 3) ? 1 : 0);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mua_rate_accumulator.md
Name: mua_rate_accumulator

Overview:
Per-channel spike-rate accumulator sitting directly upstream of the channel-state dual-port RAM. It consumes a time-multiplexed stream of threshold-crossing flags, one sample per channel. For each sample it does a read-modify-write of that channel's RAM word (current-bin count, previous-bin rate, encoder index). At each bin boundary it emits the finished per-channel rate to the downstream compression encoder.

Parameters:
CH_NUM, `CH_NUM, number of channels (RAM depth)
CH_BIT, `CH_BIT, channel index width
SPIKE_RATE_BIT, `SPIKE_RATE_BIT, width of count and rate fields
ENCODER_NUM_BIT, `ENCODER_NUM_BIT, width of encoder-index field
ENC_DEFAULT, 0, encoder index written to every channel during the init sweep

Ports:
clk  in  1  single system clock; also drives RAM wclk and rclk
rst  in  1  synchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block accepts a sample this cycle
in_ch  in  CH_BIT  channel index of sample
in_spike  in  1  1 = spike detected for this channel this sample
in_bin_end  in  1  this sample is the last of the current bin for in_ch
ram_raddr  out  CH_BIT  RAM read address, driven combinationally equal to in_ch
ram_dout  in  W  RAM registered read data; W = 2*SPIKE_RATE_BIT+ENCODER_NUM_BIT
ram_we  out  1  RAM write enable
ram_waddr  out  CH_BIT  RAM write address
ram_din  out  W  RAM write data, packed {count, prev_rate, enc} with count in the MSBs
out_valid  out  1  one-cycle pulse: a finished bin rate is on out_*
out_ch  out  CH_BIT  channel of emitted rate
out_rate  out  SPIKE_RATE_BIT  rate of the bin just closed
out_prev_rate  out  SPIKE_RATE_BIT  rate of the bin before it
out_enc  out  ENCODER_NUM_BIT  encoder index stored for the channel
busy  out  1  high during the init sweep

Behaviour:
- FSM states: INIT and RUN. Reset forces INIT, clears the init counter, clears all pipeline valid bits, and drives out_valid=0, out_* =0, ram_we=0. Any in-flight write is discarded.
- INIT: each cycle drive ram_we=1, ram_waddr=cnt, ram_din={0,0,ENC_DEFAULT}; cnt increments.
  - After writing CH_NUM-1, go to RUN next cycle. The sweep takes exactly CH_NUM cycles after reset deasserts.
  - busy=1 and in_ready=0 in INIT.
- RUN: in_ready=1 and busy=0 constantly (no backpressure). A sample is accepted at a clk edge when in_valid=1.
- Pipeline: accepted at edge T into stage 1, with {ch, spike, bin_end} registered. ram_dout is valid during cycle T..T+1.
  - Stage 1 computes the new word combinationally and drives ram_we=1, ram_waddr=ch, ram_din=new word. The write lands at edge T+1.
  - Stage 1 result is also registered into stage 2 at T+1 (ch, word, valid).
- Hazard: the RAM is read-first, so a same-channel sample accepted at T+1 reads stale data. If stage1.ch==stage2.ch and stage2 is valid, stage 1 uses stage2.word instead of ram_dout. No other hazard exists.
- Arithmetic: sum = count + spike, saturating at 2^SPIKE_RATE_BIT-1.
  - No bin_end: new word = {sum, prev, enc}.
  - bin_end: new word = {0, sum, enc}.
- enc is never modified in RUN.
- Output: at edge T+1, if stage 1 had bin_end, out_valid=1 for one cycle with out_ch=ch, out_rate=sum, out_prev_rate=old prev, out_enc=enc. Otherwise out_valid=0.
- Latency: input accept to out_valid = 1 cycle; to RAM write = 1 cycle.
- in_valid during INIT is ignored (not accepted).
- An out-of-range in_ch (≥CH_NUM) is undefined; it is not checked.
- Reset mid-RUN restarts the full INIT sweep.

Test Plan:
- Reset, hold in_valid=0 -> busy=1 for exactly CH_NUM cycles; ram_we=1 with waddr 0..CH_NUM-1; din={0,0,ENC_DEFAULT}; then in_ready=1.
- ch5: spikes 1,1,0,1 with bin_end on the 4th -> out_valid on the cycle after the 4th accept, out_ch=5, out_rate=3, out_prev_rate=0; RAM word becomes {0,3,enc}.
- ch5: 2^SPIKE_RATE_BIT+2 consecutive spikes then bin_end -> out_rate saturates at 2^SPIKE_RATE_BIT-1 and never wraps to 0.
- Back-to-back ch7 spike, ch7 spike+bin_end on consecutive cycles -> forwarding used, out_rate=2 (not 1).
- Round-robin ch0..CH_NUM-1 for two bins, ch3 spiking every sample, others silent -> second bin gives ch3 out_rate=1 and out_prev_rate=1; all other channels give 0,0.
- Assert rst for one cycle mid-stream while a bin_end sample is in stage 1 -> no out_valid and no RAM write from that sample; INIT sweep restarts at address 0.
